csa_hit_ctrl: RTL
=================

// Module: csa_hit_ctrl
// PURPOSE
//  Per-channel trigger/reset controller downstream of the charge-sensitive amp (CSA).
//  Synchronises the discriminator output on the CSA voltage and requests an ADC sample.
//  After the sample, holds the CSA in reset for a programmable number of cycles to clear accumulated charge.
//  Also issues periodic CSA resets to bleed off leakage charge.
// PARAMETERS
//  RST_CNT_W   4     width of reset_cycles; CSA reset hold up to 2^RST_CNT_W-1 cycles
//  PER_W       16    width of periodic_cycles and the periodic counter
//  SAMPLE_TO   64    cycles allowed for adc_done before timeout
// PORTS
//  clk                input   1          system clock
//  reset_n            input   1          asynchronous, active-low reset
//  hit_async          input   1          discriminator output, asynchronous to clk
//  enable             input   1          channel enable; 0 ignores hits and external triggers
//  external_trigger   input   1          forced sample request, sync to clk, level
//  periodic_reset_en  input   1          enables periodic CSA reset
//  reset_cycles       input   RST_CNT_W  CSA reset hold length; 0 treated as 1
//  periodic_cycles    input   PER_W      period between periodic resets; 0 disables
//  adc_done           input   1          ADC conversion complete (ack)
//  sample             output  1          ADC sample request (req)
//  csa_reset          output  1          drives CSA reset; CSA output = DC level when high
//  hit_event          output  1          1-cycle pulse on accepted trigger
//  timeout_err        output  1          sticky; set on ADC timeout, cleared only by reset_n
// BEHAVIOUR
//  Reset values (reset_n low):
//   - state=CSA_RST, rst_cnt=0, per_cnt=0.
//   - csa_reset=1 (CSA held in reset during chip reset); sample=0, hit_event=0, timeout_err=0.
//  Sync: hit_async -> 2-flop synchroniser (both flops reset to 0).
//   - Trigger = rising edge of sync output (3rd flop compare) OR external_trigger.
//   - Trigger qualified by enable.
//  FSM:
//   IDLE:
//    - On trigger: hit_event=1 for the transition cycle -> SAMPLE.
//    - Else if periodic_reset_en && periodic_cycles!=0 && per_cnt==periodic_cycles-1 -> CSA_RST.
//    - Trigger wins over periodic when both occur in the same cycle.
//   SAMPLE:
//    - sample=1 registered, asserted from the first SAMPLE cycle.
//    - adc_done=1 -> sample drops the next cycle -> CSA_RST.
//    - smp_cnt reaching SAMPLE_TO-1 without adc_done: timeout_err<=1, -> CSA_RST.
//   CSA_RST:
//    - csa_reset=1; rst_cnt increments each cycle.
//    - When rst_cnt==max(reset_cycles,1)-1: rst_cnt<=0 -> IDLE.
//  Latency:
//   - hit_async rise to sample high = 4 clk (2 sync + edge detect + state register).
//   - external_trigger to sample = 1 clk.
//  csa_reset and sample are registered, glitch-free, mutually exclusive, and never high in IDLE.
//  Counters:
//   - per_cnt counts only in IDLE.
//   - per_cnt clears on entry to CSA_RST from any source, and while periodic_reset_en==0.
//   - Counters saturate at their terminal values and never wrap.
//  Busy behaviour:
//   - Triggers arriving in SAMPLE or CSA_RST are dropped; no queueing.
//   - A hit still high when IDLE is re-entered does not retrigger; a new rising edge is required.
//  Config: reset_cycles and periodic_cycles are sampled live; a change mid-CSA_RST takes effect the same cycle.
//  enable deasserted mid-SAMPLE does not abort the handshake.
//  reset_n mid-operation forces csa_reset=1 and sample=0 immediately (async).
// STRUCTURE
//  Shared package (analog_core_pkg): typedef enum logic [1:0] {IDLE, SAMPLE, CSA_RST} hit_state_t.
//  Sub-module sync2 (generic 2-flop synchroniser with async active-low reset), reused for hit_async.
//  FSM, counters, and output registers stay in this module.
// TESTING
//  - Reset release with reset_cycles=3: csa_reset stays 1 for 3 clk after reset_n rises, then 0; state IDLE.
//  - hit_async pulse 5 clk wide, adc_done 10 clk after sample:
//      sample rises 4 clk after hit_async; hit_event pulses once; sample falls 1 clk after adc_done;
//      csa_reset high for reset_cycles clk; back to IDLE.
//  - No adc_done, SAMPLE_TO=64: sample held 64 clk; timeout_err=1 sticky; CSA_RST follows.
//  - periodic_reset_en=1, periodic_cycles=100, no hits: csa_reset pulses (reset_cycles wide) every 100 IDLE cycles.
//  - Trigger in same cycle as periodic terminal: SAMPLE entered; per_cnt cleared at following CSA_RST.
//  - Second hit during CSA_RST and enable=0 hits: no hit_event; reset_n low mid-SAMPLE -> sample=0, csa_reset=1 at once.

Source files
------------

// File: rtl/analog_core_pkg.sv
// Shared types for the analog front-end channel controllers.
package analog_core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CSA_RST = 2'd2
    } hit_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for signals crossing into the clk domain.
module sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/csa_hit_ctrl.sv
// Per-channel CSA trigger/reset controller: hit sync, ADC sample handshake,
// post-sample and periodic CSA reset.
//   state   | meaning
//   IDLE    | armed, waiting for a trigger or the periodic reset terminal count
//   SAMPLE  | sample request held until adc_done or timeout
//   CSA_RST | CSA held in reset for max(reset_cycles,1) cycles
module csa_hit_ctrl
    import analog_core_pkg::*;
#(
    parameter int RST_CNT_W = 4,
    parameter int PER_W     = 16,
    parameter int SAMPLE_TO = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hit_async,
    input  logic                 enable,
    input  logic                 external_trigger,
    input  logic                 periodic_reset_en,
    input  logic [RST_CNT_W-1:0] reset_cycles,
    input  logic [PER_W-1:0]     periodic_cycles,
    input  logic                 adc_done,
    output logic                 sample,
    output logic                 csa_reset,
    output logic                 hit_event,
    output logic                 timeout_err
);

    localparam int SMP_W = (SAMPLE_TO > 1) ? $clog2(SAMPLE_TO) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_TO - 1);

    hit_state_t           r_state;
    logic [RST_CNT_W-1:0] r_rst_cnt;
    logic [PER_W-1:0]     r_per_cnt;
    logic [SMP_W-1:0]     r_smp_cnt;
    logic                 r_sample;
    logic                 r_csa_reset;
    logic                 r_hit_event;
    logic                 r_timeout_err;
    logic                 r_hit_d;
    logic                 r_hit_rise;

    logic                 w_hit_sync;
    logic                 w_trigger;
    logic [RST_CNT_W-1:0] w_rst_last;
    logic                 w_per_term;

    sync2 #(.W(1)) u_hit_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (hit_async),
        .o_q     (w_hit_sync)
    );

    // Registered edge detect: a hit held high across a busy period never re-fires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_d    <= 1'b0;
            r_hit_rise <= 1'b0;
        end else begin
            r_hit_d    <= w_hit_sync;
            r_hit_rise <= w_hit_sync & ~r_hit_d;
        end
    end

    assign w_trigger  = enable & (r_hit_rise | external_trigger);
    assign w_rst_last = (reset_cycles == '0) ? '0 : reset_cycles - RST_CNT_W'(1);
    // >= rather than == so a live shrink of the config cannot strand a counter.
    assign w_per_term = periodic_reset_en && (periodic_cycles != '0) &&
                        (r_per_cnt >= periodic_cycles - PER_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= CSA_RST;
            r_rst_cnt     <= '0;
            r_per_cnt     <= '0;
            r_smp_cnt     <= '0;
            r_sample      <= 1'b0;
            r_csa_reset   <= 1'b1;
            r_hit_event   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_hit_event <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state     <= SAMPLE;
                        r_sample    <= 1'b1;
                        r_hit_event <= 1'b1;
                        r_smp_cnt   <= '0;
                    end else if (w_per_term) begin
                        r_state     <= CSA_RST;
                        r_csa_reset <= 1'b1;
                        r_rst_cnt   <= '0;
                        r_per_cnt   <= '0;
                    end else if (r_per_cnt != '1) begin
                        r_per_cnt <= r_per_cnt + PER_W'(1);
                    end
                end
                SAMPLE: begin
                    if (adc_done || (r_smp_cnt >= SMP_LAST)) begin
                        if (!adc_done) begin
                            r_timeout_err <= 1'b1;
                        end
                        r_state     <= CSA_RST;
                        r_sample    <= 1'b0;
                        r_csa_reset <= 1'b1;
                        r_rst_cnt   <= '0;
                        r_per_cnt   <= '0;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + SMP_W'(1);
                    end
                end
                CSA_RST: begin
                    if (r_rst_cnt >= w_rst_last) begin
                        r_state     <= IDLE;
                        r_csa_reset <= 1'b0;
                        r_rst_cnt   <= '0;
                    end else if (r_rst_cnt != '1) begin
                        r_rst_cnt <= r_rst_cnt + RST_CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= CSA_RST;
                    r_sample    <= 1'b0;
                    r_csa_reset <= 1'b1;
                    r_rst_cnt   <= '0;
                end
            endcase
            if (!periodic_reset_en) begin
                r_per_cnt <= '0;
            end
        end
    end

    assign sample      = r_sample;
    assign csa_reset   = r_csa_reset;
    assign hit_event   = r_hit_event;
    assign timeout_err = r_timeout_err;

endmodule
